// File: rtl/idex_hazard_reg_if.sv
// ID/EX bundle: ID-stage control/operands in, registered EX-side fields and
// hazard handshake back to IF/ID and the decoder.
interface idex_hazard_reg_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
);
    logic              RegWrite_i;
    logic              MemtoReg_i;
    logic              MemRead_i;
    logic              MemWrite_i;
    logic              ALUSrc_i;
    logic [1:0]        ALUOp_i;
    logic [DATA_W-1:0] RS1data_i;
    logic [DATA_W-1:0] RS2data_i;
    logic [DATA_W-1:0] Imm_i;
    logic [9:0]        funct_i;
    logic [4:0]        RS1addr_i;
    logic [4:0]        RS2addr_i;
    logic [4:0]        RDaddr_i;

    logic              RegWrite_o;
    logic              MemtoReg_o;
    logic              MemRead_o;
    logic              MemWrite_o;
    logic              ALUSrc_o;
    logic [1:0]        ALUOp_o;
    logic [DATA_W-1:0] RS1data_o;
    logic [DATA_W-1:0] RS2data_o;
    logic [DATA_W-1:0] Imm_o;
    logic [9:0]        funct_o;
    logic [4:0]        RS1addr_o;
    logic [4:0]        RS2addr_o;
    logic [4:0]        RDaddr_o;
    logic              Valid_o;
    logic              NoOp_o;
    logic              PCWrite_o;
    logic              IFIDWrite_o;
    logic [CNT_W-1:0]  BubbleCnt_o;

    modport master (
        output RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, ALUOp_i,
               RS1data_i, RS2data_i, Imm_i, funct_i, RS1addr_i, RS2addr_i, RDaddr_i,
        input  RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, ALUOp_o,
               RS1data_o, RS2data_o, Imm_o, funct_o, RS1addr_o, RS2addr_o, RDaddr_o,
               Valid_o, NoOp_o, PCWrite_o, IFIDWrite_o, BubbleCnt_o
    );

    modport slave (
        input  RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, ALUOp_i,
               RS1data_i, RS2data_i, Imm_i, funct_i, RS1addr_i, RS2addr_i, RDaddr_i,
        output RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, ALUOp_o,
               RS1data_o, RS2data_o, Imm_o, funct_o, RS1addr_o, RS2addr_o, RDaddr_o,
               Valid_o, NoOp_o, PCWrite_o, IFIDWrite_o, BubbleCnt_o
    );
endinterface

// File: rtl/idex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// global memory-stall freeze and a saturating bubble counter.
module idex_hazard_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic MemStall_i,
    idex_hazard_reg_if.slave bus
);
    logic hazard;

    // Both source indices are compared regardless of opcode; false stalls on
    // I-type instructions are accepted to keep this off the decoder path.
    always_comb begin
        hazard = 1'b0;
        if (bus.Valid_o && bus.MemRead_o && (bus.RDaddr_o != 5'd0) &&
            ((bus.RDaddr_o == bus.RS1addr_i) || (bus.RDaddr_o == bus.RS2addr_i)))
            hazard = 1'b1;
    end

    always_comb begin
        bus.NoOp_o      = hazard;
        bus.PCWrite_o   = ~hazard & ~MemStall_i;
        bus.IFIDWrite_o = ~hazard & ~MemStall_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus.RegWrite_o  <= 1'b0;
            bus.MemtoReg_o  <= 1'b0;
            bus.MemRead_o   <= 1'b0;
            bus.MemWrite_o  <= 1'b0;
            bus.ALUSrc_o    <= 1'b0;
            bus.ALUOp_o     <= '0;
            bus.RS1data_o   <= '0;
            bus.RS2data_o   <= '0;
            bus.Imm_o       <= '0;
            bus.funct_o     <= '0;
            bus.RS1addr_o   <= '0;
            bus.RS2addr_o   <= '0;
            bus.RDaddr_o    <= '0;
            bus.Valid_o     <= 1'b0;
            bus.BubbleCnt_o <= '0;
        end else if (!MemStall_i) begin
            bus.RS1data_o <= bus.RS1data_i;
            bus.RS2data_o <= bus.RS2data_i;
            bus.Imm_o     <= bus.Imm_i;
            bus.funct_o   <= bus.funct_i;
            bus.RS1addr_o <= bus.RS1addr_i;
            bus.RS2addr_o <= bus.RS2addr_i;
            if (hazard) begin
                bus.RegWrite_o <= 1'b0;
                bus.MemtoReg_o <= 1'b0;
                bus.MemRead_o  <= 1'b0;
                bus.MemWrite_o <= 1'b0;
                bus.ALUSrc_o   <= 1'b0;
                bus.ALUOp_o    <= '0;
                bus.RDaddr_o   <= '0;
                bus.Valid_o    <= 1'b0;
                if (bus.BubbleCnt_o != '1)
                    bus.BubbleCnt_o <= bus.BubbleCnt_o + 1'b1;
            end else begin
                bus.RegWrite_o <= bus.RegWrite_i;
                bus.MemtoReg_o <= bus.MemtoReg_i;
                bus.MemRead_o  <= bus.MemRead_i;
                bus.MemWrite_o <= bus.MemWrite_i;
                bus.ALUSrc_o   <= bus.ALUSrc_i;
                bus.ALUOp_o    <= bus.ALUOp_i;
                bus.RDaddr_o   <= bus.RDaddr_i;
                bus.Valid_o    <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_idex_hazard_reg.sv
// Directed bench for idex_hazard_reg: reset, pass-through, load-use bubble,
// x0 guard, stall overlap, reset mid-stall and counter saturation (CNT_W=2).
module tb_idex_hazard_reg;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 2;

    logic clk_i = 1'b0;
    logic rst_i;
    logic MemStall_i;
    int   n_checks = 0;
    int   n_pass   = 0;

    idex_hazard_reg_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    idex_hazard_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .MemStall_i (MemStall_i),
        .bus        (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic rw, input logic m2r, input logic mr, input logic mw,
                         input logic asrc, input logic [1:0] aop, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic [9:0] fn,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm);
        bus.RegWrite_i = rw;  bus.MemtoReg_i = m2r; bus.MemRead_i = mr;
        bus.MemWrite_i = mw;  bus.ALUSrc_i   = asrc; bus.ALUOp_i  = aop;
        bus.RS1addr_i  = rs1; bus.RS2addr_i  = rs2; bus.RDaddr_i  = rd;
        bus.funct_i    = fn;  bus.RS1data_i  = d1;  bus.RS2data_i = d2;
        bus.Imm_i      = imm;
        #1;
    endtask

    task automatic lw(input logic [4:0] rd, input logic [4:0] rs1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, rs1, 5'd0, rd, 10'h002,
              32'h1000, 32'h0, 32'h0);
    endtask

    task automatic add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, rs1, rs2, rd, 10'h000,
              32'h11, 32'h22, 32'h0);
    endtask

    function automatic logic [159:0] all_regs();
        return {bus.RegWrite_o, bus.MemtoReg_o, bus.MemRead_o, bus.MemWrite_o,
                bus.ALUSrc_o, bus.ALUOp_o, bus.RS1data_o, bus.RS2data_o, bus.Imm_o,
                bus.funct_o, bus.RS1addr_o, bus.RS2addr_o, bus.RDaddr_o,
                bus.Valid_o, bus.BubbleCnt_o};
    endfunction

    function automatic logic [159:0] ctrl();
        return {bus.RegWrite_o, bus.MemtoReg_o, bus.MemRead_o, bus.MemWrite_o,
                bus.ALUSrc_o, bus.ALUOp_o, bus.RDaddr_o, bus.Valid_o};
    endfunction

    logic [1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        rst_i = 1'b1;
        MemStall_i = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 5'd7, 5'd9, 5'd7, 10'h3ff,
              $urandom, $urandom, $urandom);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("reset_regs", all_regs(), '0);
            check("reset_pcwrite", {bus.PCWrite_o, bus.IFIDWrite_o, bus.NoOp_o}, 3'b110);
        end
        rst_i = 1'b0;

        // add x3,x1,x2
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 5'd1, 5'd2, 5'd3, 10'h000,
              32'hA5A5_0001, 32'h5A5A_0002, 32'h0);
        check("pass_noop", bus.NoOp_o, 1'b0);
        tick();
        check("pass_ctrl", ctrl(), {5'b10000, 2'b10, 5'd3, 1'b1});
        check("pass_data", {bus.RS1data_o, bus.RS2data_o, bus.RS1addr_o, bus.RS2addr_o},
              {32'hA5A5_0001, 32'h5A5A_0002, 5'd1, 5'd2});
        check("pass_noop_after", bus.NoOp_o, 1'b0);

        // lw x5,0(x1) ; add x6,x5,x2
        lw(5'd5, 5'd1);
        tick();
        check("lw_ctrl", ctrl(), {5'b11101, 2'b00, 5'd5, 1'b1});
        add(5'd6, 5'd5, 5'd2);
        check("lu_hazard", {bus.NoOp_o, bus.PCWrite_o, bus.IFIDWrite_o}, 3'b100);
        tick();
        check("lu_bubble", ctrl(), '0);
        check("lu_cnt", bus.BubbleCnt_o, 2'd1);
        check("lu_release", {bus.NoOp_o, bus.PCWrite_o, bus.IFIDWrite_o}, 3'b011);
        tick();
        check("lu_add", ctrl(), {5'b10000, 2'b10, 5'd6, 1'b1});

        // lw x0 ; add x6,x0,x2
        lw(5'd0, 5'd1);
        tick();
        add(5'd6, 5'd0, 5'd2);
        check("x0_nohazard", {bus.NoOp_o, bus.PCWrite_o}, 2'b01);
        tick();
        check("x0_add", ctrl(), {5'b10000, 2'b10, 5'd6, 1'b1});
        check("x0_cnt", bus.BubbleCnt_o, 2'd1);

        // stall overlapping a pending hazard
        lw(5'd5, 5'd1);
        tick();
        MemStall_i = 1'b1;
        add(5'd6, 5'd5, 5'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold", ctrl(), {5'b11101, 2'b00, 5'd5, 1'b1});
            check("stall_data", bus.RS1data_o, 32'h1000);
            check("stall_cnt", bus.BubbleCnt_o, 2'd1);
            check("stall_flags", {bus.NoOp_o, bus.PCWrite_o, bus.IFIDWrite_o}, 3'b100);
        end
        MemStall_i = 1'b0;
        #1;
        check("stall_drop_hazard", {bus.NoOp_o, bus.PCWrite_o}, 2'b10);
        tick();
        check("stall_bubble", ctrl(), '0);
        check("stall_bubble_cnt", bus.BubbleCnt_o, 2'd2);
        tick();
        check("stall_add", ctrl(), {5'b10000, 2'b10, 5'd6, 1'b1});

        // reset during a pending hazard
        lw(5'd5, 5'd1);
        tick();
        add(5'd6, 5'd5, 5'd2);
        check("rstmid_hazard", bus.NoOp_o, 1'b1);
        rst_i = 1'b1;
        tick();
        check("rstmid_regs", all_regs(), '0);
        check("rstmid_pcwrite", {bus.NoOp_o, bus.PCWrite_o, bus.IFIDWrite_o}, 3'b011);
        MemStall_i = 1'b1;
        #1;
        check("rstmid_stall_pcwrite", bus.PCWrite_o, 1'b0);
        tick();
        MemStall_i = 1'b0;
        rst_i = 1'b0;

        // saturation: alternate rs1 / rs2 dependency
        for (int i = 0; i < 5; i++) begin
            lw(5'd5, 5'd1);
            tick();
            if (i % 2 == 0) add(5'd6, 5'd5, 5'd2);
            else            add(5'd6, 5'd2, 5'd5);
            check("sat_hazard", bus.NoOp_o, 1'b1);
            tick();
            check("sat_cnt", bus.BubbleCnt_o, sat_exp[i]);
            tick();
            check("sat_add", ctrl(), {5'b10000, 2'b10, 5'd6, 1'b1});
        end

        // independent back-to-back loads
        lw(5'd7, 5'd1);
        tick();
        lw(5'd8, 5'd2);
        check("b2b_nohazard", bus.NoOp_o, 1'b0);
        tick();
        check("b2b_second", ctrl(), {5'b11101, 2'b00, 5'd8, 1'b1});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
